// File: rtl/fetch_align_buffer.sv
// Instruction fetch front end: word fetch into a halfword queue, re-aligned into RV32I/RVC instructions.
// Optional build macro FETCH_PERF_CNT_EN adds accepted-instruction and decode-stall counters.
module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          QDEPTH_HW = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_rvc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_instr_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int PW = $clog2(QDEPTH_HW);
  localparam int CW = PW + 1;

  logic [15:0]   q [QDEPTH_HW];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc, head_pc;
  logic          skip_lo;

  logic [15:0]   h0, h1;
  logic          is32;
  logic          fetch_en, pop_en;
  logic [CW-1:0] push_n, pop_n;

  assign h0   = q[head];
  assign h1   = q[head + PW'(1)];
  assign is32 = (h0[1:0] == 2'b11);

  assign rom_addr_o     = fetch_pc;
  assign instr_valid_o  = is32 ? (count >= CW'(2)) : (count != '0);
  assign instr_o        = is32 ? {h1, h0} : {16'h0000, h0};
  assign instr_pc_o     = head_pc;
  assign instr_is_rvc_o = !is32;

  // Fetch only when a whole word is guaranteed to fit, judged on count before this cycle's pop.
  assign fetch_en = !rst_i && !redirect_i && (count <= CW'(QDEPTH_HW - 2));
  assign pop_en   = !rst_i && !redirect_i && instr_valid_o && instr_ready_i;
  assign push_n   = fetch_en ? (skip_lo ? CW'(1) : CW'(2)) : '0;
  assign pop_n    = pop_en ? (is32 ? CW'(2) : CW'(1)) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      skip_lo  <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      for (int i = 0; i < QDEPTH_HW; i++) q[i] <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      head_pc  <= {redirect_pc_i[31:1], 1'b0};
      skip_lo  <= redirect_pc_i[1];
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (fetch_en) begin
        // A redirect to an odd halfword drops the low half of the first word.
        if (skip_lo) begin
          q[tail] <= rom_data_i[31:16];
        end else begin
          q[tail]          <= rom_data_i[15:0];
          q[tail + PW'(1)] <= rom_data_i[31:16];
        end
        tail     <= tail + PW'(push_n);
        fetch_pc <= fetch_pc + 32'd4;
        skip_lo  <= 1'b0;
      end
      if (pop_en) begin
        head    <= head + PW'(pop_n);
        head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
      end
      count <= count + push_n - pop_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_instr_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (pop_en) perf_instr_cnt_o <= perf_instr_cnt_o + 32'd1;
      if (instr_ready_i && !instr_valid_o && !redirect_i)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: small ROM model, hand-computed instruction stream.
module tb_fetch_align_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_rvc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_instr_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rom [16];
  assign rom_data_i = rom[rom_addr_o[5:2]];

  always #5 clk_i = ~clk_i;

  fetch_align_buffer #(.RESET_PC(32'h0000_0000), .QDEPTH_HW(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_is_rvc_o (instr_is_rvc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_instr_cnt_o (perf_instr_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] ins,
                              input logic [31:0] pc, input logic rvc);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    chk({tag, "_instr"}, instr_o, ins);
    chk({tag, "_pc"}, instr_pc_o, pc);
    chk({tag, "_rvc"}, 32'(instr_is_rvc_o), 32'(rvc));
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    step();
    redirect_i    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0001_0001;
    rom[0] = 32'h00A0_0093;
    rom[1] = 32'h4505_4081;
    rom[2] = 32'h0093_4501;
    rom[3] = 32'h0000_00A0;

    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b1;
    step(); step();
    rst_i = 1'b0;

    // Cycle after reset: fetching word 0, nothing presented, outputs not X
    chk("rst_addr", rom_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_i", perf_instr_cnt_o, 32'd0);
    chk("rst_perf_s", perf_stall_cnt_o, 32'd0);
`endif
    step(); expect_instr("aligned32", 32'h00A0_0093, 32'h0, 1'b0);
    step(); expect_instr("rvc_a", 32'h0000_4081, 32'h4, 1'b1);
    step(); expect_instr("rvc_b", 32'h0000_4505, 32'h6, 1'b1);

    // Redirect to 0x6 with 3 halfwords queued
    do_redirect(32'h0000_0006);
    chk("redir6_addr", rom_addr_o, 32'h4);
    chk("redir6_valid", 32'(instr_valid_o), 32'd0);
    step(); expect_instr("redir6_first", 32'h0000_4505, 32'h6, 1'b1);
    step(); expect_instr("strad_rvc", 32'h0000_4501, 32'h8, 1'b1);
    step(); expect_instr("strad_32", 32'h00A0_0093, 32'hA, 1'b0);
    step(); expect_instr("after_strad", 32'h0000_0000, 32'hE, 1'b1);

    // Redirect to 0xA: only the upper half of 0x8 is queued, 32-bit instr must wait
    do_redirect(32'h0000_000A);
    chk("redirA_addr", rom_addr_o, 32'h8);
    chk("redirA_valid0", 32'(instr_valid_o), 32'd0);
    step();
    chk("redirA_half", 32'(instr_valid_o), 32'd0);
    chk("redirA_addr2", rom_addr_o, 32'hC);
    step(); expect_instr("redirA_32", 32'h00A0_0093, 32'hA, 1'b0);

    // Backpressure from address 0
    instr_ready_i = 1'b0;
    do_redirect(32'h0000_0000);
    chk("bp_addr0", rom_addr_o, 32'h0);
    step(); expect_instr("bp_first", 32'h00A0_0093, 32'h0, 1'b0);
    chk("bp_addr1", rom_addr_o, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_instr("bp_hold", 32'h00A0_0093, 32'h0, 1'b0);
      chk("bp_addr_hold", rom_addr_o, 32'h8);
    end
    instr_ready_i = 1'b1;
    step(); expect_instr("bp_res_a", 32'h0000_4081, 32'h4, 1'b1);
    step(); expect_instr("bp_res_b", 32'h0000_4505, 32'h6, 1'b1);
    step(); expect_instr("bp_res_c", 32'h0000_4501, 32'h8, 1'b1);

    // Address wrap: odd halfword at the top of memory, then PC 0
    do_redirect(32'hFFFF_FFFE);
    chk("wrap_addr", rom_addr_o, 32'hFFFF_FFFC);
    chk("wrap_valid0", 32'(instr_valid_o), 32'd0);
    step(); expect_instr("wrap_top", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    chk("wrap_addr0", rom_addr_o, 32'h0);
    step(); expect_instr("wrap_zero", 32'h00A0_0093, 32'h0, 1'b0);

    // Reset with queue partly full
    instr_ready_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    chk("mrst_valid", 32'(instr_valid_o), 32'd0);
    chk("mrst_addr", rom_addr_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_perf_i", perf_instr_cnt_o, 32'd0);
    chk("mrst_perf_s", perf_stall_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;
    instr_ready_i = 1'b1;
    step(); expect_instr("mrst_a", 32'h00A0_0093, 32'h0, 1'b0);
    step(); expect_instr("mrst_b", 32'h0000_4081, 32'h4, 1'b1);
    step(); expect_instr("mrst_c", 32'h0000_4505, 32'h6, 1'b1);
    step();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_instr3", perf_instr_cnt_o, 32'd3);
    chk("perf_stall1", perf_stall_cnt_o, 32'd1);
`endif
    expect_instr("mrst_d", 32'h0000_4501, 32'h8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Instruction-fetch front end of the rv32imac core. Sits directly upstream of the memory block's ROM port: drives the ROM fetch address and consumes the returned 32-bit word.
- Fetches word-aligned 32-bit words into a halfword queue and re-aligns them into whole RV32I/RVC instructions, including 32-bit instructions that straddle a word boundary.
- Presents one instruction at a time to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap target) by flushing the queue and refetching.

Parameters:
RESET_PC  32'h0000_0000  PC of first instruction after reset; bits [1:0] must be 0
QDEPTH_HW  4  queue depth in 16-bit halfwords; power of 2, >= 4

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, synchronous, active-high
rom_addr_o  output  32  fetch address to ROM, always word-aligned ([1:0]=0)
rom_data_i  input  32  ROM read data, combinational from rom_addr_o, little-endian
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  new PC; bit0 ignored (treated as 0)
instr_valid_o  output  1  instr_o/instr_pc_o hold a complete instruction
instr_ready_i  input  1  decode accepts instruction this cycle
instr_o  output  32  instruction; RVC zero-extended in [31:16]
instr_pc_o  output  32  byte address of instr_o
instr_is_rvc_o  output  1  1 = 16-bit instruction

Behaviour:
- State: fetch_pc (word-aligned), skip_lo flag, halfword queue (head/tail pointers, count 0..QDEPTH_HW), head_pc.
- Reset, synchronous (rst_i high at edge): fetch_pc=RESET_PC, skip_lo=0, count=0, head_pc=RESET_PC. During and after reset, instr_valid_o=0 until the first push. rom_addr_o=fetch_pc. Reset overrides redirect and the handshake.
- rom_addr_o is fetch_pc, combinational from the register.
- Fetch condition: !rst_i && !redirect_i && count <= QDEPTH_HW-2. Uses count before this cycle's pop.
- On fetch:
  - skip_lo=0: push rom_data_i[15:0], then rom_data_i[31:16].
  - skip_lo=1: push only [31:16], then clear skip_lo.
  - fetch_pc += 4.
- Latency: a word fetched in cycle N is visible at the outputs in cycle N+1. Outputs are combinational from queue state. No bypass.
- Decode of the head halfword h0:
  - h0[1:0] != 2'b11 → RVC. Valid when count >= 1. instr_o = {16'h0, h0}, instr_is_rvc_o=1.
  - h0[1:0] == 2'b11 → 32-bit. Valid when count >= 2. instr_o = {h1, h0}, instr_is_rvc_o=0.
  - When not valid, instr_o, instr_pc_o and instr_is_rvc_o are don't-care but must not be X after reset. Drive from queue contents, which are reset to 0.
- Pop when instr_valid_o && instr_ready_i: remove 1 halfword (RVC) or 2 (32-bit). head_pc += 2 or 4.
- Count update: count_next = count + push_n − pop_n. Simultaneous push and pop are allowed. Queue never overflows because of the fetch condition.
- Outputs are held stable while instr_valid_o=1 and instr_ready_i=0.
- Redirect (redirect_i=1, no reset):
  - Queue flushed (count=0, pointers reset). No fetch and no pop that cycle; the handshake is ignored.
  - fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - skip_lo = redirect_pc_i[1].
  - head_pc = {redirect_pc_i[31:1], 1'b0}.
  - Next cycle rom_addr_o = new fetch_pc.
- Back-to-back redirects: the last one wins. Each flushes.
- Wrap-around:
  - fetch_pc and head_pc wrap modulo 2^32.
  - Queue pointers wrap modulo QDEPTH_HW.
  - A 32-bit instruction may span the pointer wrap.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_instr_cnt_o [31:0] and perf_stall_cnt_o [31:0].
  - Both are reset to 0 by rst_i and wrap at 2^32.
  - instr counter: +1 per accepted instruction (valid && ready).
  - stall counter: +1 per cycle with instr_ready_i=1 && instr_valid_o=0 && !redirect_i && !rst_i.
- Undefined: ports and counters do not exist. Fetch/align behaviour is identical.

Test Plan:
- Aligned 32-bit: ROM[0]=0x00A00093, ready=1, release reset → cycle after reset: rom_addr_o=0x0. Next cycle: valid=1, instr_o=0x00A00093, pc=0x0, rvc=0.
- RVC pair: ROM word@0x4=0x45054081 → instr 0x00004081 pc 0x4 rvc=1, then 0x00004505 pc 0x6 rvc=1, on consecutive cycles.
- Straddling: word@0x8=0x00934501, word@0xC=0x000000A0 → 0x00004501 pc 0x8, then 0x00A00093 pc 0xA rvc=0. The second instruction is not valid before word@0xC has been pushed.
- Redirect to 0x6 mid-stream with 3 halfwords queued:
  - Next cycle: rom_addr_o=0x4, no valid.
  - Following cycle: instr 0x00004505 pc 0x6. Stale instructions are never presented.
- Backpressure: ready=0 for 5 cycles → count saturates at 4, rom_addr_o stops advancing, instr_o/instr_pc_o stable. ready=1 → stream resumes with no lost or duplicated PC.
- Reset mid-operation: assert rst_i with the queue half full → next cycle valid=0, rom_addr_o=RESET_PC. With FETCH_PERF_CNT_EN: both counters read 0, and after 3 accepted instructions perf_instr_cnt_o=3.
